dcf77_frame_decoder: RTL and testbench

Assembles the per-second DCF77 bit stream from the pulse classifier into a 59-bit minute frame. On each minute mark it validates the frame: length, marker bits, parity and BCD ranges. Valid frames are published as registered date/time fields, which drive the if_date_time signals (all except second). Invalid frames raise a one-cycle error pulse with a cause code and leave the previous outputs untouched.

---
 rtl/dcf77_frame_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_dcf77_frame_decoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-frame assembler: collects second bits, validates each frame on the minute mark, publishes date/time.
// Define LEAP_SECOND_EN to accept 60-bit frames when the leap-second announcement bit (a2) is set.
module dcf77_frame_decoder #(
    parameter int unsigned RANGE_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_strobe,
    input  logic        bit_value,
    input  logic        minute_mark,
    output logic [13:0] broadcast,
    output logic        r,
    output logic        a1,
    output logic        z1,
    output logic        z2,
    output logic        a2,
    output logic [7:0]  minute,
    output logic [7:0]  hour,
    output logic [7:0]  day,
    output logic [2:0]  day_of_week,
    output logic [7:0]  month,
    output logic [7:0]  year,
    output logic        p1,
    output logic        p2,
    output logic        p3,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [2:0]  error_code,
    output logic [1:0]  dbg_state_o
);

`ifdef LEAP_SECOND_EN
    localparam logic [5:0] MAX_BITS = 6'd60;
    localparam logic       LEAP_EN  = 1'b1;
`else
    localparam logic [5:0] MAX_BITS = 6'd59;
    localparam logic       LEAP_EN  = 1'b0;
`endif

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_LENGTH   = 3'd1;
    localparam logic [2:0] ERR_MARKER   = 3'd2;
    localparam logic [2:0] ERR_PARITY   = 3'd3;
    localparam logic [2:0] ERR_RANGE    = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [59:0] frame_q;

    logic [13:0] broadcast_q;
    logic        r_q, a1_q, z1_q, z2_q, a2_q;
    logic [7:0]  minute_q, hour_q, day_q, month_q, year_q;
    logic [2:0]  dow_q;
    logic        p1_q, p2_q, p3_q;
    logic        frame_valid_q, frame_error_q;
    logic [2:0]  error_code_q;

    // Fields as they sit in the assembled frame, already zero-extended to output width.
    logic [7:0] minute_d, hour_d, day_d, month_d, year_d;
    logic [2:0] dow_d;

    assign minute_d = {1'b0, frame_q[27:21]};
    assign hour_d   = {2'b00, frame_q[34:29]};
    assign day_d    = {2'b00, frame_q[41:36]};
    assign dow_d    = frame_q[44:42];
    assign month_d  = {3'b000, frame_q[49:45]};
    assign year_d   = frame_q[57:50];

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    logic       leap_frame, len_ok, marker_ok, parity_ok;
    logic       digits_ok, values_ok, range_ok;
    logic [2:0] code_d;

    always_comb begin
        leap_frame = LEAP_EN && (cnt_q == 6'd60) && frame_q[19];
        len_ok     = (cnt_q == 6'd59) || leap_frame;
        marker_ok  = !frame_q[0] && frame_q[20] && !(leap_frame && frame_q[59]);
        parity_ok  = !(^frame_q[28:21]) && !(^frame_q[35:29]) && !(^frame_q[58:36]);

        // With every digit <= 9, BCD compares order the same as the decimal values.
        digits_ok = digit_ok(minute_d[3:0]) && digit_ok(hour_d[3:0]) &&
                    digit_ok(day_d[3:0]) && digit_ok(month_d[3:0]) &&
                    digit_ok(year_d[3:0]) && digit_ok(year_d[7:4]);
        values_ok = (minute_d <= 8'h59) && (hour_d <= 8'h23) &&
                    (day_d != 8'h00) && (day_d <= 8'h31) && (dow_d != 3'd0) &&
                    (month_d != 8'h00) && (month_d <= 8'h12) &&
                    (frame_q[17] != frame_q[18]);
        range_ok  = digits_ok && values_ok;

        code_d = ERR_NONE;
        if (!len_ok) begin
            code_d = ERR_LENGTH;
        end else if (!marker_ok) begin
            code_d = ERR_MARKER;
        end else if (!parity_ok) begin
            code_d = ERR_PARITY;
        end else if ((RANGE_CHECK != 0) && !range_ok) begin
            code_d = ERR_RANGE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_UNSYNC;
            cnt_q         <= 6'd0;
            frame_q       <= 60'd0;
            broadcast_q   <= 14'd0;
            r_q           <= 1'b0;
            a1_q          <= 1'b0;
            z1_q          <= 1'b0;
            z2_q          <= 1'b0;
            a2_q          <= 1'b0;
            minute_q      <= 8'd0;
            hour_q        <= 8'd0;
            day_q         <= 8'd0;
            dow_q         <= 3'd0;
            month_q       <= 8'd0;
            year_q        <= 8'd0;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            p3_q          <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            error_code_q  <= ERR_NONE;
        end else begin
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                ST_UNSYNC: begin
                    if (minute_mark) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= 6'd0;
                    end
                end
                ST_COLLECT: begin
                    // A bit arriving together with the minute mark is dropped.
                    if (minute_mark) begin
                        state_q <= ST_CHECK;
                    end else if (bit_strobe) begin
                        if (cnt_q == MAX_BITS) begin
                            frame_error_q <= 1'b1;
                            error_code_q  <= ERR_OVERFLOW;
                            state_q       <= ST_UNSYNC;
                            cnt_q         <= 6'd0;
                        end else begin
                            frame_q[cnt_q] <= bit_value;
                            cnt_q          <= cnt_q + 6'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (code_d == ERR_NONE) begin
                        broadcast_q   <= frame_q[14:1];
                        r_q           <= frame_q[15];
                        a1_q          <= frame_q[16];
                        z1_q          <= frame_q[17];
                        z2_q          <= frame_q[18];
                        a2_q          <= frame_q[19];
                        minute_q      <= minute_d;
                        hour_q        <= hour_d;
                        day_q         <= day_d;
                        dow_q         <= dow_d;
                        month_q       <= month_d;
                        year_q        <= year_d;
                        p1_q          <= frame_q[28];
                        p2_q          <= frame_q[35];
                        p3_q          <= frame_q[58];
                        frame_valid_q <= 1'b1;
                        error_code_q  <= ERR_NONE;
                    end else begin
                        frame_error_q <= 1'b1;
                        error_code_q  <= code_d;
                    end
                    cnt_q   <= 6'd0;
                    state_q <= ST_COLLECT;
                end
                default: begin
                    state_q <= ST_UNSYNC;
                end
            endcase
        end
    end

    assign broadcast   = broadcast_q;
    assign r           = r_q;
    assign a1          = a1_q;
    assign z1          = z1_q;
    assign z2          = z2_q;
    assign a2          = a2_q;
    assign minute      = minute_q;
    assign hour        = hour_q;
    assign day         = day_q;
    assign day_of_week = dow_q;
    assign month       = month_q;
    assign year        = year_q;
    assign p1          = p1_q;
    assign p2          = p2_q;
    assign p3          = p3_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign error_code  = error_code_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Bench for dcf77_frame_decoder: two instances (range check on/off) compared every cycle against a frame-level model.
module tb_dcf77_frame_decoder;

`ifdef LEAP_SECOND_EN
    localparam int MAX_BITS = 60;
    localparam bit LEAP_ON  = 1'b1;
`else
    localparam int MAX_BITS = 59;
    localparam bit LEAP_ON  = 1'b0;
`endif

    typedef struct packed {
        logic [13:0] broadcast;
        logic        r;
        logic        a1;
        logic        z1;
        logic        z2;
        logic        a2;
        logic [7:0]  minute;
        logic [7:0]  hour;
        logic [7:0]  day;
        logic [2:0]  dow;
        logic [7:0]  month;
        logic [7:0]  year;
        logic        p1;
        logic        p2;
        logic        p3;
        logic        valid;
        logic        error;
        logic [2:0]  code;
    } obs_t;

    // Clock and reset
    logic clk;
    logic rst;
    logic bit_strobe;
    logic bit_value;
    logic minute_mark;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] rc_broadcast, nr_broadcast;
    logic        rc_r, rc_a1, rc_z1, rc_z2, rc_a2, nr_r, nr_a1, nr_z1, nr_z2, nr_a2;
    logic [7:0]  rc_minute, rc_hour, rc_day, rc_month, rc_year;
    logic [7:0]  nr_minute, nr_hour, nr_day, nr_month, nr_year;
    logic [2:0]  rc_dow, nr_dow, rc_code, nr_code;
    logic        rc_p1, rc_p2, rc_p3, nr_p1, nr_p2, nr_p3;
    logic        rc_valid, rc_error, nr_valid, nr_error;
    logic [1:0]  rc_state, nr_state;
    obs_t        rc_o, nr_o;

    assign rc_o = {rc_broadcast, rc_r, rc_a1, rc_z1, rc_z2, rc_a2, rc_minute, rc_hour, rc_day,
                   rc_dow, rc_month, rc_year, rc_p1, rc_p2, rc_p3, rc_valid, rc_error, rc_code};
    assign nr_o = {nr_broadcast, nr_r, nr_a1, nr_z1, nr_z2, nr_a2, nr_minute, nr_hour, nr_day,
                   nr_dow, nr_month, nr_year, nr_p1, nr_p2, nr_p3, nr_valid, nr_error, nr_code};

    dcf77_frame_decoder #(.RANGE_CHECK(1)) dut_rc (
        .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .bit_value(bit_value),
        .minute_mark(minute_mark), .broadcast(rc_broadcast), .r(rc_r), .a1(rc_a1),
        .z1(rc_z1), .z2(rc_z2), .a2(rc_a2), .minute(rc_minute), .hour(rc_hour),
        .day(rc_day), .day_of_week(rc_dow), .month(rc_month), .year(rc_year),
        .p1(rc_p1), .p2(rc_p2), .p3(rc_p3), .frame_valid(rc_valid),
        .frame_error(rc_error), .error_code(rc_code), .dbg_state_o(rc_state)
    );

    dcf77_frame_decoder #(.RANGE_CHECK(0)) dut_nr (
        .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .bit_value(bit_value),
        .minute_mark(minute_mark), .broadcast(nr_broadcast), .r(nr_r), .a1(nr_a1),
        .z1(nr_z1), .z2(nr_z2), .a2(nr_a2), .minute(nr_minute), .hour(nr_hour),
        .day(nr_day), .day_of_week(nr_dow), .month(nr_month), .year(nr_year),
        .p1(nr_p1), .p2(nr_p2), .p3(nr_p3), .frame_valid(nr_valid),
        .frame_error(nr_error), .error_code(nr_code), .dbg_state_o(nr_state)
    );

    int   n_checks;
    int   n_errors;
    bit   model_ready;
    bit   synced;
    bit   checking;
    bit   bits_q[$];
    obs_t exp_rc;
    obs_t exp_nr;

    // Reference model: frame bits kept as a queue, decoded with decimal arithmetic.
    function automatic int fld(input int lo, input int n);
        int v;
        v = 0;
        for (int k = 0; k < n; k++) v += int'(bits_q[lo + k]) << k;
        return v;
    endfunction

    function automatic int ones(input int lo, input int hi);
        int c;
        c = 0;
        for (int k = lo; k <= hi; k++) c += int'(bits_q[k]);
        return c;
    endfunction

    function automatic int eval_code(input bit rc);
        int len;
        bit leap60;
        int mu, mt, hu, ht, du, dt, dw, ou, ot, yu, yt;
        len = bits_q.size();
        leap60 = LEAP_ON && (len == 60) && bits_q[19];
        if (len != 59 && !leap60) return 1;
        if (bits_q[0] != 1'b0 || bits_q[20] != 1'b1) return 2;
        if (leap60 && bits_q[59]) return 2;
        if ((ones(21, 28) % 2) != 0 || (ones(29, 35) % 2) != 0 || (ones(36, 58) % 2) != 0) return 3;
        if (!rc) return 0;
        mu = fld(21, 4); mt = fld(25, 3);
        hu = fld(29, 4); ht = fld(33, 2);
        du = fld(36, 4); dt = fld(40, 2);
        dw = fld(42, 3);
        ou = fld(45, 4); ot = fld(49, 1);
        yu = fld(50, 4); yt = fld(54, 4);
        if (mu > 9 || hu > 9 || du > 9 || ou > 9 || yu > 9 || yt > 9) return 4;
        if (mt * 10 + mu > 59) return 4;
        if (ht * 10 + hu > 23) return 4;
        if (dt * 10 + du == 0 || dt * 10 + du > 31) return 4;
        if (dw == 0) return 4;
        if (ot * 10 + ou == 0 || ot * 10 + ou > 12) return 4;
        if (bits_q[17] == bits_q[18]) return 4;
        return 0;
    endfunction

    function automatic obs_t apply_result(input obs_t prev, input int code);
        obs_t o;
        o = prev;
        if (code == 0) begin
            for (int i = 0; i < 14; i++) o.broadcast[i] = bits_q[i + 1];
            o.r      = bits_q[15];
            o.a1     = bits_q[16];
            o.z1     = bits_q[17];
            o.z2     = bits_q[18];
            o.a2     = bits_q[19];
            o.minute = 8'(fld(21, 4) + 16 * fld(25, 3));
            o.hour   = 8'(fld(29, 4) + 16 * fld(33, 2));
            o.day    = 8'(fld(36, 4) + 16 * fld(40, 2));
            o.dow    = 3'(fld(42, 3));
            o.month  = 8'(fld(45, 4) + 16 * fld(49, 1));
            o.year   = 8'(fld(50, 4) + 16 * fld(54, 4));
            o.p1     = bits_q[28];
            o.p2     = bits_q[35];
            o.p3     = bits_q[58];
            o.valid  = 1'b1;
            o.code   = 3'd0;
        end else begin
            o.error = 1'b1;
            o.code  = 3'(code);
        end
        return o;
    endfunction

    task automatic model_step();
        exp_rc.valid = 1'b0; exp_rc.error = 1'b0;
        exp_nr.valid = 1'b0; exp_nr.error = 1'b0;
        if (rst) begin
            exp_rc = '0; exp_nr = '0;
            synced = 1'b0; checking = 1'b0;
            bits_q.delete();
            model_ready = 1'b1;
        end else if (!model_ready) begin
            synced = 1'b0;
        end else if (checking) begin
            exp_rc = apply_result(exp_rc, eval_code(1'b1));
            exp_nr = apply_result(exp_nr, eval_code(1'b0));
            checking = 1'b0;
            bits_q.delete();
        end else if (!synced) begin
            if (minute_mark) begin
                synced = 1'b1;
                bits_q.delete();
            end
        end else if (minute_mark) begin
            checking = 1'b1;
        end else if (bit_strobe) begin
            if (bits_q.size() == MAX_BITS) begin
                exp_rc.error = 1'b1; exp_rc.code = 3'd5;
                exp_nr.error = 1'b1; exp_nr.code = 3'd5;
                synced = 1'b0;
                bits_q.delete();
            end else begin
                bits_q.push_back(bit_value);
            end
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Driver tasks: called at posedge+1, each consumes whole clock cycles.
    task automatic drive_cycle(input bit s, input bit v, input bit m);
        bit_strobe = s; bit_value = v; minute_mark = m;
        @(posedge clk); #1;
        bit_strobe = 1'b0; bit_value = 1'b0; minute_mark = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bits(input logic [63:0] f, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, f[i], 1'b0);
            idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    // Returns with the check result visible on the outputs.
    task automatic mark_and_wait(input bit with_bit, input bit v);
        drive_cycle(with_bit, v, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [63:0] build_frame(input logic [7:0] mn, input logic [7:0] hr,
                                                input logic [7:0] dy, input logic [2:0] dw,
                                                input logic [7:0] mo, input logic [7:0] yr,
                                                input bit zz1, input bit zz2, input bit aa2,
                                                input bit b59);
        logic [63:0] f;
        f = '0;
        f[14:1]  = 14'($urandom());
        f[16:15] = 2'($urandom());
        f[17]    = zz1;
        f[18]    = zz2;
        f[19]    = aa2;
        f[20]    = 1'b1;
        f[27:21] = mn[6:0];
        f[28]    = ^mn[6:0];
        f[34:29] = hr[5:0];
        f[35]    = ^hr[5:0];
        f[41:36] = dy[5:0];
        f[44:42] = dw;
        f[49:45] = mo[4:0];
        f[57:50] = yr;
        f[58]    = ^f[57:36];
        f[59]    = b59;
        return f;
    endfunction

    logic [63:0] f_ref, f_bad, f_tmp;

    initial begin
        n_checks = 0; n_errors = 0;
        model_ready = 1'b0; synced = 1'b0; checking = 1'b0;
        exp_rc = '0; exp_nr = '0;
        rst = 1'b1; bit_strobe = 1'b0; bit_value = 1'b0; minute_mark = 1'b0;

        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (model_ready) begin
                    chk_obs("rc_cycle", rc_o, exp_rc);
                    chk_obs("nr_cycle", nr_o, exp_nr);
                    chk_lit("state_agree", 32'(rc_state), 32'(nr_state));
                end
            end
        join_none

        idle(3);
        rst = 1'b0;
        chk_lit("reset_minute", 32'(rc_minute), 32'h0);
        chk_lit("reset_code", 32'(rc_code), 32'h0);
        chk_lit("reset_valid", 32'(rc_valid), 32'h0);

        // Fri 2024-03-15 14:37 CET
        f_ref = build_frame(8'h37, 8'h14, 8'h15, 3'd5, 8'h03, 8'h24, 1'b0, 1'b1, 1'b0, 1'b0);
        mark_and_wait(1'b0, 1'b0);
        send_bits(f_ref, 59, 2);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("ref_valid", 32'(rc_valid), 32'h1);
        chk_lit("ref_minute", 32'(rc_minute), 32'h37);
        chk_lit("ref_hour", 32'(rc_hour), 32'h14);
        chk_lit("ref_day", 32'(rc_day), 32'h15);
        chk_lit("ref_dow", 32'(rc_dow), 32'h5);
        chk_lit("ref_month", 32'(rc_month), 32'h03);
        chk_lit("ref_year", 32'(rc_year), 32'h24);
        chk_lit("ref_parity", 32'({rc_p1, rc_p2, rc_p3}), 32'h5);
        chk_lit("ref_code", 32'(rc_code), 32'h0);

        f_tmp = f_ref;
        f_tmp[25] = ~f_tmp[25];
        send_bits(f_tmp, 59, 1);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("parity_error", 32'(rc_error), 32'h1);
        chk_lit("parity_code", 32'(rc_code), 32'h3);
        chk_lit("parity_hold_minute", 32'(rc_minute), 32'h37);

        send_bits(f_ref, 58, 1);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("short_code", 32'(rc_code), 32'h1);

        send_bits(f_ref, MAX_BITS, 1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        chk_lit("overflow_error", 32'(rc_error), 32'h1);
        chk_lit("overflow_code", 32'(rc_code), 32'h5);
        idle(3);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("resync_no_error", 32'(rc_error), 32'h0);
        chk_lit("resync_no_valid", 32'(rc_valid), 32'h0);

        f_bad = build_frame(8'h6A, 8'h14, 8'h15, 3'd5, 8'h03, 8'h24, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(f_bad, 59, 2);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("range_code", 32'(rc_code), 32'h4);
        chk_lit("range_hold_minute", 32'(rc_minute), 32'h37);
        chk_lit("norange_valid", 32'(nr_valid), 32'h1);
        chk_lit("norange_minute", 32'(nr_minute), 32'h6A);

        send_bits(f_ref, 59, 1);
        mark_and_wait(1'b1, 1'b1);
        chk_lit("coincident_valid", 32'(rc_valid), 32'h1);
        chk_lit("coincident_minute", 32'(nr_minute), 32'h37);

        send_bits(f_ref, 30, 1);
        do_reset();
        chk_lit("midreset_minute", 32'(rc_minute), 32'h0);
        chk_lit("midreset_year", 32'(rc_year), 32'h0);
        send_bits(f_ref, 59, 0);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("unsync_no_valid", 32'(rc_valid), 32'h0);
        chk_lit("unsync_no_error", 32'(rc_error), 32'h0);
        send_bits(f_ref, 59, 1);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("after_reset_valid", 32'(rc_valid), 32'h1);
        chk_lit("after_reset_minute", 32'(rc_minute), 32'h37);

`ifdef LEAP_SECOND_EN
        f_tmp = build_frame(8'h59, 8'h00, 8'h01, 3'd1, 8'h01, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(f_tmp, 60, 1);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("leap_valid", 32'(rc_valid), 32'h1);
        chk_lit("leap_a2", 32'(rc_a2), 32'h1);
        f_tmp[59] = 1'b1;
        send_bits(f_tmp, 60, 1);
        mark_and_wait(1'b0, 1'b0);
        chk_lit("leap_bit59_code", 32'(rc_code), 32'h2);
`endif

        for (int fr = 0; fr < 40; fr++) begin
            logic [7:0] mn, hr, dy, mo, yr;
            logic [2:0] dw;
            bit zz1, zz2, aa2;
            int len, sel, idx;
            mn = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(127, 0)) : to_bcd(int'($urandom_range(59, 0)));
            hr = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(63, 0)) : to_bcd(int'($urandom_range(23, 0)));
            dy = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(63, 0)) : to_bcd(int'($urandom_range(31, 1)));
            mo = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(31, 0)) : to_bcd(int'($urandom_range(12, 1)));
            yr = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 0)) : to_bcd(int'($urandom_range(99, 0)));
            dw = 3'($urandom_range(7, 0));
            zz1 = 1'($urandom_range(1, 0));
            zz2 = ($urandom_range(5, 0) == 0) ? zz1 : ~zz1;
            aa2 = ($urandom_range(2, 0) == 0);
            f_tmp = build_frame(mn, hr, dy, dw, mo, yr, zz1, zz2, aa2, ($urandom_range(3, 0) == 0));
            if ($urandom_range(3, 0) == 0) begin
                idx = int'($urandom_range(59, 0));
                f_tmp[idx] = ~f_tmp[idx];
            end
            sel = int'($urandom_range(15, 0));
            case (sel)
                0:       len = 58;
                1:       len = 57;
                2:       len = MAX_BITS + 1;
                3:       len = 60;
                default: len = (LEAP_ON && aa2) ? 60 : 59;
            endcase
            if ($urandom_range(19, 0) == 0) begin
                send_bits(f_tmp, int'($urandom_range(40, 1)), 2);
                do_reset();
                mark_and_wait(1'b0, 1'b0);
            end else begin
                send_bits(f_tmp, len, 3);
                if ($urandom_range(7, 0) == 0) mark_and_wait(1'b1, 1'($urandom_range(1, 0)));
                else mark_and_wait(1'b0, 1'b0);
            end
            idle(int'($urandom_range(2, 0)));
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
